// File: rtl/dht11_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_reader
//  Description : DHT11 single-wire driver: start pulse, response, 40-bit frame,
//                checksum check, humidity/temperature bytes with strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module dht11_reader #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_LOW_US  = 20000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       data_rdy,
    output logic [7:0] temperature,
    output logic [7:0] humidity,
    output logic       err
);

    localparam int C_TICK_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? (CLK_FREQ_HZ / 1_000_000) : 1;
    localparam int C_DIV_W    = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;

    localparam logic [C_DIV_W-1:0] C_TICK_LAST  = C_DIV_W'(C_TICK_DIV - 1);
    localparam logic [C_DIV_W-1:0] C_TICK_ONE   = C_DIV_W'(1);
    localparam logic [14:0]        C_US_MAX     = 15'h7FFF;
    localparam logic [14:0]        C_START_LAST = 15'(START_LOW_US - 1);
    localparam logic [14:0]        C_THRESH     = 15'(BIT_THRESH_US);
    localparam logic [14:0]        C_TIMEOUT    = 15'(TIMEOUT_US);
    localparam logic [5:0]         C_LAST_BIT   = 6'd39;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START_LOW = 4'd1,
        S_START_REL = 4'd2,
        S_RESP_LOW  = 4'd3,
        S_RESP_HIGH = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_CHECK     = 4'd7
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               line_q;
    logic [C_DIV_W-1:0] tick_q;
    logic [14:0]        us_cnt_q, us_cnt_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [39:0]        shift_q, shift_d;
    logic [7:0]         hum_q, hum_d;
    logic [7:0]         temp_q, temp_d;
    logic               rdy_q, rdy_d;
    logic               err_q, err_d;
    logic               oe_q, oe_d;

    logic               w_line;
    logic               w_fall;
    logic               w_rise;
    logic               w_us_tick;
    logic               w_timeout;
    logic               w_bit_val;
    logic [7:0]         w_sum;

    // Line synchronizer; idles high (external pull-up) so reset does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            line_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], dht_in};
            line_q <= sync_q[1];
        end
    end

    assign w_line = sync_q[1];
    assign w_fall = line_q & ~w_line;
    assign w_rise = ~line_q & w_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (w_us_tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + C_TICK_ONE;
        end
    end

    assign w_us_tick = (tick_q == C_TICK_LAST);

    always_comb begin
        us_cnt_d = us_cnt_q;
        if (state_d != state_q) begin
            us_cnt_d = '0;
        end else if (w_us_tick && (us_cnt_q != C_US_MAX)) begin
            us_cnt_d = us_cnt_q + 15'd1;
        end
    end

    assign w_timeout = (us_cnt_q >= C_TIMEOUT);
    // us_cnt restarts one cycle after the rising edge, so it reads one tick short of the high time.
    assign w_bit_val = (us_cnt_q >= C_THRESH);
    assign w_sum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hum_d     = hum_q;
        temp_d    = temp_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sample_en) begin
                    state_d = S_START_LOW;
                end
            end
            S_START_LOW: begin
                if (w_us_tick && (us_cnt_q >= C_START_LAST)) begin
                    state_d = S_START_REL;
                end
            end
            S_START_REL: begin
                if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (w_fall) begin
                    state_d = S_RESP_LOW;
                end
            end
            S_RESP_LOW: begin
                if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (w_rise) begin
                    state_d = S_RESP_HIGH;
                end
            end
            S_RESP_HIGH: begin
                if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (w_fall) begin
                    bit_cnt_d = '0;
                    state_d   = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (w_rise) begin
                    state_d = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (w_fall) begin
                    shift_d = {shift_q[38:0], w_bit_val};
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_d = S_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        state_d   = S_BIT_LOW;
                    end
                end
            end
            S_CHECK: begin
                if (w_sum == shift_q[7:0]) begin
                    hum_d  = shift_q[39:32];
                    temp_d = shift_q[23:16];
                    rdy_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pad enable is registered so the open-drain driver never sees state-decode glitches.
    assign oe_d = (state_d == S_START_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            us_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hum_q     <= '0;
            temp_q    <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_cnt_q  <= us_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hum_q     <= hum_d;
            temp_q    <= temp_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            oe_q      <= oe_d;
        end
    end

    assign dht_oe      = oe_q;
    assign busy        = (state_q != S_IDLE);
    assign data_rdy    = rdy_q;
    assign err         = err_q;
    assign humidity    = hum_q;
    assign temperature = temp_q;

endmodule
`default_nettype wire
